// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: shares one external memory port between instruction fetch (IF) and
// the MEM stage. Each requester has a one-entry result buffer, so a completed access
// survives a pipeline stall. The block also drives the 6-bit pipeline stall vector.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   if_req, if_addr, if_inst      fetch request (level), address, buffered instruction
//   mem_req, mem_we, mem_addr,    load/store request (level) and command
//   mem_sel, mem_wdata
//   mem_rdata                     buffered load data
//   stallreq_id, stallreq_ex      stall requests from ID (load-use) and EX (multi-cycle)
//   flush                         invalidates both buffers; an in-flight result is dropped
//   ram_req, ram_we, ram_addr,    registered memory command; held until ram_done
//   ram_sel, ram_wdata
//   ram_rdata, ram_done           read data and one-cycle completion pulse
//   stall                         [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
module mem_port_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // Instruction fetch
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_inst,
  // MEM stage
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  // Pipeline control
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                flush,
  // External memory port
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  input  logic                ram_done,
  // Stall vector
  output logic [5:0]          stall
);

  localparam int unsigned SelW = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle,
    StIfBusy,
    StMemBusy
  } state_e;

  state_e              state_q;

  logic                if_buf_valid_q;
  logic [ADDR_W-1:0]   if_buf_addr_q;
  logic [DATA_W-1:0]   if_buf_data_q;
  logic                mem_buf_valid_q;
  logic [DATA_W-1:0]   mem_buf_data_q;

  // Set by a flush while a transfer is outstanding; the transfer's result is then dropped.
  logic                discard_q;

  logic                if_hit;
  logic                mem_hit;
  logic                if_miss;
  logic                mem_miss;

  assign if_hit   = if_buf_valid_q && (if_buf_addr_q == if_addr);
  assign mem_hit  = mem_buf_valid_q;
  assign if_miss  = if_req && !if_hit;
  assign mem_miss = mem_req && !mem_hit;

  assign if_inst   = if_buf_data_q;
  assign mem_rdata = mem_buf_data_q;

  // Later stages have priority: a stall at a stage also freezes every stage before it.
  always_comb begin
    stall = 6'b000000;
    if (rst) begin
      stall = 6'b000000;
    end else if (mem_miss) begin
      stall = 6'b011111;
    end else if (stallreq_ex) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end else if (if_miss) begin
      stall = 6'b000011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      ram_req         <= 1'b0;
      ram_we          <= 1'b0;
      ram_addr        <= '0;
      ram_sel         <= '0;
      ram_wdata       <= '0;
      if_buf_valid_q  <= 1'b0;
      if_buf_addr_q   <= '0;
      if_buf_data_q   <= '0;
      mem_buf_valid_q <= 1'b0;
      mem_buf_data_q  <= '0;
      discard_q       <= 1'b0;
    end else begin
      // A buffered result is consumed once its stage is allowed to advance.
      if (mem_hit && !stall[4]) begin
        mem_buf_valid_q <= 1'b0;
      end
      if (if_hit && !stall[1]) begin
        if_buf_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (mem_miss) begin
            ram_req   <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_sel   <= mem_sel;
            ram_wdata <= mem_wdata;
            state_q   <= StMemBusy;
          end else if (if_miss) begin
            ram_req        <= 1'b1;
            ram_we         <= 1'b0;
            ram_addr       <= if_addr;
            ram_sel        <= {SelW{1'b1}};
            // Any entry still held is for a different address and is now stale.
            if_buf_valid_q <= 1'b0;
            state_q        <= StIfBusy;
          end
        end

        StIfBusy, StMemBusy: begin
          if (ram_done) begin
            ram_req   <= 1'b0;
            state_q   <= StIdle;
            discard_q <= 1'b0;
            if (!flush && !discard_q) begin
              if (state_q == StIfBusy) begin
                if_buf_valid_q <= 1'b1;
                if_buf_addr_q  <= ram_addr;
                if_buf_data_q  <= ram_rdata;
              end else begin
                // For stores the valid bit doubles as the completion flag.
                mem_buf_valid_q <= 1'b1;
                mem_buf_data_q  <= ram_rdata;
              end
            end
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          ram_req <= 1'b0;
        end
      endcase

      // Flush overrides any capture or consumption in the same cycle.
      if (flush) begin
        if_buf_valid_q  <= 1'b0;
        mem_buf_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Testbench for mem_port_ctrl: directed scenarios followed by a randomized run checked
// against a transaction-level reference model with a random-latency memory responder.
module tb_mem_port_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        flush;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_done;
  logic [5:0]  stall;

  mem_port_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_inst    (if_inst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_sel    (mem_sel),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex),
    .flush      (flush),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_sel    (ram_sel),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_done   (ram_done),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int rises;
  logic prev_req;

  // Reference model: one outstanding transfer plus the two result buffers.
  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       pend[$];
  logic        m_discard;
  logic        m_if_v;
  logic [31:0] m_if_a;
  logic [31:0] m_if_d;
  logic        m_mem_v;
  logic [31:0] m_mem_d;
  int          lat;
  logic        done_sent;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, tracking rising edges of ram_req.
  task automatic step();
    @(negedge clk);
    if (ram_req && !prev_req) rises++;
    prev_req = ram_req;
  endtask

  initial begin
    logic        ih;
    logic        mh;
    logic [5:0]  es;
    total = 0; bad = 0; rises = 0; prev_req = 1'b0;
    rst = 1'b1;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_sel = 0;
    mem_wdata = 0; stallreq_id = 0; stallreq_ex = 0; flush = 0; ram_rdata = 0; ram_done = 0;

    // Reset: stall forced low even with a request pending.
    step(); if_req = 1; if_addr = 32'h100; #1;
    chk("rst_stall", stall, 6'b000000);
    chk("rst_ram_req", ram_req, 0);
    step(); #1;
    chk("rst_if_inst", if_inst, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);

    // Fetch only, done 3 cycles after the request.
    step(); rst = 0; #1;
    chk("f_stall0", stall, 6'b000011);
    step(); #1;
    chk("f_ram_req", ram_req, 1);
    chk("f_ram_addr", ram_addr, 32'h100);
    chk("f_ram_we", ram_we, 0);
    chk("f_ram_sel", ram_sel, 4'hf);
    chk("f_stall1", stall, 6'b000011);
    step(); #1;
    chk("f_stall2", stall, 6'b000011);
    step(); ram_done = 1; ram_rdata = 32'h24010005; #1;
    chk("f_stall3", stall, 6'b000011);
    step(); ram_done = 0; #1;
    chk("f_req_drop", ram_req, 0);
    chk("f_if_inst", if_inst, 32'h24010005);
    chk("f_stall_rel", stall, 6'b000000);
    step(); #1;
    chk("f_buf_clear", stall, 6'b000011);
    if_req = 0;

    // Load, done after 2 cycles.
    step(); mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_sel = 4'hf; #1;
    chk("l_stall0", stall, 6'b011111);
    step(); #1;
    chk("l_ram_req", ram_req, 1);
    chk("l_ram_addr", ram_addr, 32'h200);
    chk("l_ram_we", ram_we, 0);
    chk("l_stall1", stall, 6'b011111);
    step(); ram_done = 1; ram_rdata = 32'hDEADBEEF; #1;
    chk("l_stall2", stall, 6'b011111);
    step(); ram_done = 0; #1;
    chk("l_mem_rdata", mem_rdata, 32'hDEADBEEF);
    chk("l_stall_rel", stall, 6'b000000);
    mem_req = 0;

    // Conflict: MEM first, then IF.
    step(); if_req = 1; if_addr = 32'h300; mem_req = 1; mem_addr = 32'h400; #1;
    chk("c_stall0", stall, 6'b011111);
    step(); #1;
    chk("c_first_addr", ram_addr, 32'h400);
    ram_done = 1; ram_rdata = 32'h12345678;
    step(); ram_done = 0; #1;
    chk("c_stall1", stall, 6'b000011);
    chk("c_mem_rdata", mem_rdata, 32'h12345678);
    mem_req = 0;
    step(); #1;
    chk("c_if_req", ram_req, 1);
    chk("c_if_addr", ram_addr, 32'h300);
    chk("c_stall2", stall, 6'b000011);
    ram_done = 1; ram_rdata = 32'h0BADF00D;
    step(); ram_done = 0; #1;
    chk("c_stall3", stall, 6'b000000);
    chk("c_if_inst", if_inst, 32'h0BADF00D);
    if_req = 0;
    step();

    // Store arriving mid-fetch: fetch completes and is buffered, no refetch.
    rises = 0;
    step(); if_req = 1; if_addr = 32'h500; #1;
    chk("mf_stall0", stall, 6'b000011);
    step(); mem_req = 1; mem_we = 1; mem_addr = 32'h600; mem_sel = 4'b0011;
    mem_wdata = 32'h11223344; #1;
    chk("mf_stall1", stall, 6'b011111);
    step(); ram_done = 1; ram_rdata = 32'hAAAA0001; #1;
    chk("mf_not_aborted", ram_addr, 32'h500);
    step(); ram_done = 0; #1;
    chk("mf_stall2", stall, 6'b011111);
    chk("mf_if_inst", if_inst, 32'hAAAA0001);
    step(); #1;
    chk("mf_st_addr", ram_addr, 32'h600);
    chk("mf_st_we", ram_we, 1);
    chk("mf_st_sel", ram_sel, 4'b0011);
    chk("mf_st_wdata", ram_wdata, 32'h11223344);
    ram_done = 1; ram_rdata = 32'h0;
    step(); ram_done = 0; #1;
    chk("mf_stall3", stall, 6'b000000);
    mem_req = 0; mem_we = 0; if_req = 0;
    step(); step(); #1;
    chk("mf_rises", rises, 2);

    // Flush coincident with fetch completion: result dropped, refetch follows.
    step(); if_req = 1; if_addr = 32'h700;
    step(); ram_done = 1; ram_rdata = 32'h55; flush = 1; #1;
    chk("fl_busy", ram_req, 1);
    step(); ram_done = 0; flush = 0; #1;
    chk("fl_refetch_stall", stall, 6'b000011);
    chk("fl_idle", ram_req, 0);
    step(); #1;
    chk("fl_refetch_req", ram_req, 1);
    chk("fl_refetch_addr", ram_addr, 32'h700);
    ram_done = 1; ram_rdata = 32'h66;
    step(); ram_done = 0; #1;
    chk("fl_if_inst", if_inst, 32'h66);
    chk("fl_stall_rel", stall, 6'b000000);
    if_req = 0;
    // Flush earlier in the transfer also drops the result.
    step(); if_req = 1; if_addr = 32'h710;
    step(); flush = 1;
    step(); flush = 0; ram_done = 1; ram_rdata = 32'h77;
    step(); ram_done = 0; #1;
    chk("fl_early_drop", stall, 6'b000011);
    if_req = 0;
    step(); stallreq_ex = 1; #1;
    chk("ex_only", stall, 6'b001111);
    stallreq_id = 1; #1;
    chk("ex_id", stall, 6'b001111);
    stallreq_ex = 0; #1;
    chk("id_only", stall, 6'b000111);
    stallreq_id = 0;

    // Reset in the middle of a load.
    step(); mem_req = 1; mem_we = 0; mem_addr = 32'h800;
    step(); #1;
    chk("rb_busy", ram_req, 1);
    rst = 1; #1;
    chk("rb_stall_rst", stall, 6'b000000);
    step(); rst = 0; mem_req = 0; #1;
    chk("rb_ram_req", ram_req, 0);
    chk("rb_ram_addr", ram_addr, 0);
    chk("rb_mem_rdata", mem_rdata, 0);
    chk("rb_if_inst", if_inst, 0);
    chk("rb_stall", stall, 6'b000000);
    if_req = 1; if_addr = 32'h100; #1;
    chk("rb_if_invalid", stall, 6'b000011);
    if_req = 0;

    // Randomized run against the reference model.
    pend.delete(); m_discard = 0; m_if_v = 0; m_if_a = 0; m_if_d = 0;
    m_mem_v = 0; m_mem_d = 0; lat = -1; done_sent = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      ram_done    = 0;
      if_req      = ($urandom_range(0, 9) < 7);
      if_addr     = 32'h100 + 32'($urandom_range(0, 2)) * 4;
      mem_req     = ($urandom_range(0, 9) < 4);
      mem_we      = $urandom_range(0, 1) == 1;
      mem_addr    = $urandom;
      mem_sel     = 4'($urandom);
      mem_wdata   = $urandom;
      stallreq_ex = ($urandom_range(0, 9) == 0);
      stallreq_id = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      if (!ram_req) done_sent = 0;
      if (ram_req && !done_sent) begin
        if (lat < 0) lat = $urandom_range(0, 2);
        if (lat == 0) begin
          ram_done  = 1;
          ram_rdata = $urandom;
          done_sent = 1;
          lat       = -1;
        end else begin
          lat--;
        end
      end
      #1;
      ih = m_if_v && (m_if_a == if_addr);
      mh = m_mem_v;
      if (mem_req && !mh)        es = 6'b011111;
      else if (stallreq_ex)      es = 6'b001111;
      else if (stallreq_id)      es = 6'b000111;
      else if (if_req && !ih)    es = 6'b000011;
      else                       es = 6'b000000;
      chk("r_stall", stall, es);
      chk("r_ram_req", ram_req, pend.size() != 0);
      if (pend.size() != 0) begin
        chk("r_ram_addr", ram_addr, pend[0].addr);
        chk("r_ram_we", ram_we, pend[0].we);
        chk("r_ram_sel", ram_sel, pend[0].sel);
        if (pend[0].is_mem) chk("r_ram_wdata", ram_wdata, pend[0].wdata);
      end
      if (m_if_v) chk("r_if_inst", if_inst, m_if_d);
      if (m_mem_v) chk("r_mem_rdata", mem_rdata, m_mem_d);

      // Effect of the coming clock edge.
      if (mh && !es[4]) m_mem_v = 0;
      if (ih && !es[1]) m_if_v = 0;
      if (pend.size() == 0) begin
        if (mem_req && !mh) begin
          pend.push_back('{is_mem: 1'b1, we: mem_we, addr: mem_addr, sel: mem_sel,
                           wdata: mem_wdata});
        end else if (if_req && !ih) begin
          pend.push_back('{is_mem: 1'b0, we: 1'b0, addr: if_addr, sel: 4'hf, wdata: 32'h0});
          m_if_v = 0;
        end
      end else if (ram_done) begin
        if (!flush && !m_discard) begin
          if (pend[0].is_mem) begin
            m_mem_v = 1; m_mem_d = ram_rdata;
          end else begin
            m_if_v = 1; m_if_a = pend[0].addr; m_if_d = ram_rdata;
          end
        end
        m_discard = 0;
        pend.delete();
      end else if (flush) begin
        m_discard = 1;
      end
      if (flush) begin
        m_if_v  = 0;
        m_mem_v = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
